// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game-setup logic: board/LFSR defaults, the LFSR
// feedback tap mask and its step function, and the mine placer state type.
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int          MAX_N_DEF     = 16;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    // Polynomial x^16+x^14+x^13+x^11+1; with the register shifting right the
    // taps 16,14,13,11 sit on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        PLACE = 2'b10,
        DONE  = 2'b11
    } placer_state_t;

    // One Fibonacci step: XOR of the tapped bits enters at the top.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {^(cur & LFSR_TAPS), cur[15:1]};
    endfunction

endpackage

// File: rtl/mine_placer_if.sv
// -----------------------------------------------------------------------------
// mine_placer_if
// Bundle between the level selector / board readers and the mine placer.
//   start, mines_in, button_num, safe_x, safe_y : level configuration pulse
//   busy, done, mines_placed                    : placement progress
//   q_x, q_y / q_mine                           : registered map query port
// master = selector / reader side, slave = mine_placer.
// -----------------------------------------------------------------------------
interface mine_placer_if;

    logic       start;
    logic [5:0] mines_in;
    logic [4:0] button_num;
    logic [3:0] safe_x;
    logic [3:0] safe_y;
    logic       busy;
    logic       done;
    logic [5:0] mines_placed;
    logic [3:0] q_x;
    logic [3:0] q_y;
    logic       q_mine;

    modport master (
        output start, mines_in, button_num, safe_x, safe_y, q_x, q_y,
        input  busy, done, mines_placed, q_mine
    );

    modport slave (
        input  start, mines_in, button_num, safe_x, safe_y, q_x, q_y,
        output busy, done, mines_placed, q_mine
    );

endinterface

// File: rtl/lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit maximal Fibonacci LFSR, no enable.
//   clk   : clock
//   rst   : asynchronous active-high reset, loads SEED
//   state : current register value
// -----------------------------------------------------------------------------
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    logic [15:0] state_r;

    // Advance one step every cycle from reset onward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SEED;
        end else begin
            state_r <= lfsr_next(state_r);
        end
    end

    assign state = state_r;

endmodule

// File: rtl/mine_placer.sv
// -----------------------------------------------------------------------------
// mine_placer
// Captures a level configuration, clears a MAX_N x MAX_N mine map and fills it
// with pseudo-random mines drawn from a free-running LFSR, skipping cells that
// are off-board, already mined, or the protected first-click cell.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mine_placer_if.slave (config pulse, busy/done/count, query)
// -----------------------------------------------------------------------------
module mine_placer
    import game_pkg::*;
#(
    parameter int          MAX_N     = MAX_N_DEF,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mine_placer_if.slave bus
);

    localparam int         MAP_BITS = MAX_N * MAX_N;
    localparam int         IDX_W    = $clog2(MAP_BITS);
    localparam logic [4:0] MAX_N_V  = 5'(MAX_N);

    placer_state_t         state_r;
    logic [4:0]            n_eff_r;
    logic [3:0]            safe_x_r;
    logic [3:0]            safe_y_r;
    logic [5:0]            target_r;
    logic [5:0]            placed_r;
    logic [MAP_BITS-1:0]   map_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  q_mine_r;

    logic [15:0]           lfsr_s;
    logic [7:0]            unused_lfsr_hi_s;
    logic [3:0]            cand_x_s;
    logic [3:0]            cand_y_s;
    logic [IDX_W-1:0]      cand_idx_s;
    logic                  accept_s;
    logic [5:0]            placed_inc_s;
    logic [4:0]            cfg_n_s;
    logic [8:0]            cfg_sq_s;
    logic [5:0]            cfg_target_s;
    logic                  q_in_range_s;
    logic [IDX_W-1:0]      q_idx_s;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_s)
    );

    // The upper byte only matters for the LFSR's own feedback.
    assign unused_lfsr_hi_s = lfsr_s[15:8];

    // Clamp the requested level: board side to MAX_N, mine count so that at
    // least the safe cell stays free (no mines at all on a 0x0 or 1x1 board).
    always_comb begin
        cfg_n_s      = 5'd0;
        cfg_sq_s     = 9'd0;
        cfg_target_s = 6'd0;
        if (bus.button_num > MAX_N_V) begin
            cfg_n_s = MAX_N_V;
        end else begin
            cfg_n_s = bus.button_num;
        end
        cfg_sq_s = 9'(cfg_n_s) * 9'(cfg_n_s);
        if (cfg_n_s <= 5'd1) begin
            cfg_target_s = 6'd0;
        end else if ({3'b000, bus.mines_in} > (cfg_sq_s - 9'd1)) begin
            cfg_target_s = 6'(cfg_sq_s - 9'd1);
        end else begin
            cfg_target_s = bus.mines_in;
        end
    end

    // Candidate cell from the low LFSR byte and its acceptance test.
    always_comb begin
        cand_x_s     = lfsr_s[3:0];
        cand_y_s     = lfsr_s[7:4];
        cand_idx_s   = IDX_W'(int'(cand_y_s) * MAX_N + int'(cand_x_s));
        placed_inc_s = placed_r + 6'd1;
        if (({1'b0, cand_x_s} < n_eff_r) && ({1'b0, cand_y_s} < n_eff_r) &&
            !((cand_x_s == safe_x_r) && (cand_y_s == safe_y_r))) begin
            accept_s = ~map_r[cand_idx_s];
        end else begin
            accept_s = 1'b0;
        end
    end

    // Query decode; off-board coordinates always read as empty.
    always_comb begin
        q_idx_s = IDX_W'(int'(bus.q_y) * MAX_N + int'(bus.q_x));
        if (({1'b0, bus.q_x} < n_eff_r) && ({1'b0, bus.q_y} < n_eff_r)) begin
            q_in_range_s = 1'b1;
        end else begin
            q_in_range_s = 1'b0;
        end
    end

    // Placement sequencer with registered busy/done/count outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            n_eff_r  <= 5'd0;
            safe_x_r <= 4'd0;
            safe_y_r <= 4'd0;
            target_r <= 6'd0;
            placed_r <= 6'd0;
            map_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        n_eff_r  <= cfg_n_s;
                        safe_x_r <= bus.safe_x;
                        safe_y_r <= bus.safe_y;
                        target_r <= cfg_target_s;
                        busy_r   <= 1'b1;
                        state_r  <= CLEAR;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                CLEAR: begin
                    map_r    <= '0;
                    placed_r <= 6'd0;
                    if (target_r == 6'd0) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= PLACE;
                    end
                end
                PLACE: begin
                    if (accept_s) begin
                        map_r[cand_idx_s] <= 1'b1;
                        placed_r          <= placed_inc_s;
                        if (placed_inc_s == target_r) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Registered map read; sees writes from the previous edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_mine_r <= 1'b0;
        end else begin
            q_mine_r <= q_in_range_s ? map_r[q_idx_s] : 1'b0;
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.mines_placed = placed_r;
    assign bus.q_mine       = q_mine_r;

endmodule

// File: tb/tb_mine_placer.sv
// -----------------------------------------------------------------------------
// tb_mine_placer
// Self-checking bench for mine_placer. A reference model replays the LFSR
// sequence from its seed and fills a 16x16 array following the placement
// rules, predicting the final map, count and completion time.
// -----------------------------------------------------------------------------
module tb_mine_placer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mine_placer_if bus ();

    mine_placer #(.MAX_N(16), .LFSR_SEED(16'hACE1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, shifting right, seeded like the DUT.
    function automatic logic [15:0] m_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= m_next(m_lfsr);
    end

    bit          exp_map [16][16];
    bit          got_map [16][16];
    int          exp_target;
    int          exp_done_edge;
    logic [15:0] snap;
    logic        busy_c1;
    int          done_edge;
    int          busy_low;
    int          done_pulses;

    // Reference placement: walk the LFSR sequence cell by cell.
    task automatic model_place(input int mines, input int bn, input int sx, input int sy,
                               input logic [15:0] v0);
        int n, sq, cnt, cyc, x, y;
        logic [15:0] v;
        foreach (exp_map[i, j]) exp_map[i][j] = 1'b0;
        n  = (bn > 16) ? 16 : bn;
        sq = n * n;
        exp_target = (n <= 1) ? 0 : ((mines < sq - 1) ? mines : sq - 1);
        cnt = 0;
        cyc = 0;
        v   = v0;
        while (cnt < exp_target && cyc < 20000) begin
            v = m_next(v);
            cyc++;
            x = int'(v[3:0]);
            y = int'(v[7:4]);
            if (x < n && y < n && !(x == sx && y == sy) && !exp_map[y][x]) begin
                exp_map[y][x] = 1'b1;
                cnt++;
            end
        end
        exp_done_edge = cyc + 1;
    endtask

    task automatic start_pulse(input int mines, input int bn, input int sx, input int sy);
        @(negedge clk);
        bus.mines_in   = 6'(mines);
        bus.button_num = 5'(bn);
        bus.safe_x     = 4'(sx);
        bus.safe_y     = 4'(sy);
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_c1   = bus.busy;
        snap      = m_lfsr;
    endtask

    // Count edges after the start edge until done, then watch for extra pulses.
    task automatic wait_done(input int e0);
        int e;
        e = e0;
        done_edge = -1;
        busy_low = 0;
        done_pulses = 0;
        while (done_edge < 0 && e < 8000) begin
            @(posedge clk);
            #1;
            e++;
            if (bus.done === 1'b1) done_edge = e;
            else if (bus.busy !== 1'b1) busy_low++;
        end
        if (done_edge >= 0) done_pulses = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) done_pulses++;
        end
    endtask

    task automatic read_map();
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                bus.q_x = 4'(x);
                bus.q_y = 4'(y);
                @(posedge clk);
                #1;
                got_map[y][x] = (bus.q_mine === 1'b1);
            end
        end
    endtask

    function automatic int map_mismatches();
        int m;
        m = 0;
        foreach (got_map[i, j]) if (got_map[i][j] != exp_map[i][j]) m++;
        return m;
    endfunction

    function automatic int map_popcount();
        int c;
        c = 0;
        foreach (got_map[i, j]) if (got_map[i][j]) c++;
        return c;
    endfunction

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks += 4;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        if (bus.mines_placed !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.mines_placed); end
        if (bus.q_mine !== 1'b0) begin errors++; $display("FAIL reset_qmine: got %b expected 0", bus.q_mine); end
    endtask

    task automatic test_level1();
        start_pulse(19, 8, 3, 3);
        model_place(19, 8, 3, 3, snap);
        wait_done(0);
        read_map();
        checks += 7;
        if (busy_c1 !== 1'b1) begin errors++; $display("FAIL l1_busy_c1: got %b expected 1", busy_c1); end
        if (done_edge != exp_done_edge) begin errors++; $display("FAIL l1_done_edge: got %0d expected %0d", done_edge, exp_done_edge); end
        if (done_pulses != 1) begin errors++; $display("FAIL l1_done_pulses: got %0d expected 1", done_pulses); end
        if (bus.mines_placed !== 6'd19) begin errors++; $display("FAIL l1_count: got %0d expected 19", bus.mines_placed); end
        if (map_mismatches() != 0) begin errors++; $display("FAIL l1_map: got %0d differing cells expected 0", map_mismatches()); end
        if (map_popcount() != 19) begin errors++; $display("FAIL l1_popcount: got %0d expected 19", map_popcount()); end
        if (got_map[3][3] != 1'b0) begin errors++; $display("FAIL l1_safe: got %b expected 0", got_map[3][3]); end
    endtask

    task automatic test_level3();
        start_pulse(63, 16, 0, 0);
        model_place(63, 16, 0, 0, snap);
        wait_done(0);
        read_map();
        checks += 6;
        if (busy_c1 !== 1'b1 || busy_low != 0) begin errors++; $display("FAIL l3_busy: got c1=%b low_cycles=%0d expected c1=1 low_cycles=0", busy_c1, busy_low); end
        if (done_edge != exp_done_edge) begin errors++; $display("FAIL l3_done_edge: got %0d expected %0d", done_edge, exp_done_edge); end
        if (bus.mines_placed !== 6'd63) begin errors++; $display("FAIL l3_count: got %0d expected 63", bus.mines_placed); end
        if (map_mismatches() != 0) begin errors++; $display("FAIL l3_map: got %0d differing cells expected 0", map_mismatches()); end
        if (map_popcount() != 63) begin errors++; $display("FAIL l3_popcount: got %0d expected 63", map_popcount()); end
        if (got_map[0][0] != 1'b0) begin errors++; $display("FAIL l3_safe: got %b expected 0", got_map[0][0]); end
    endtask

    task automatic test_zero_mines();
        start_pulse(0, 10, 4, 4);
        wait_done(0);
        read_map();
        checks += 5;
        if (busy_c1 !== 1'b1) begin errors++; $display("FAIL zero_busy_c1: got %b expected 1", busy_c1); end
        if (done_edge != 1) begin errors++; $display("FAIL zero_done_edge: got %0d expected 1", done_edge); end
        if (done_pulses != 1) begin errors++; $display("FAIL zero_done_pulses: got %0d expected 1", done_pulses); end
        if (bus.mines_placed !== 6'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", bus.mines_placed); end
        if (map_popcount() != 0) begin errors++; $display("FAIL zero_map: got %0d mines expected 0", map_popcount()); end
    endtask

    task automatic test_saturation();
        start_pulse(40, 4, 1, 2);
        model_place(40, 4, 1, 2, snap);
        wait_done(0);
        read_map();
        checks += 4;
        if (bus.mines_placed !== 6'd15) begin errors++; $display("FAIL sat_count: got %0d expected 15", bus.mines_placed); end
        if (map_popcount() != 15) begin errors++; $display("FAIL sat_popcount: got %0d expected 15", map_popcount()); end
        if (got_map[2][1] != 1'b0) begin errors++; $display("FAIL sat_safe: got %b expected 0", got_map[2][1]); end
        if (done_edge != exp_done_edge) begin errors++; $display("FAIL sat_done_edge: got %0d expected %0d", done_edge, exp_done_edge); end
        start_pulse(5, 20, 7, 7);
        model_place(5, 20, 7, 7, snap);
        wait_done(0);
        read_map();
        checks += 2;
        if (bus.mines_placed !== 6'd5) begin errors++; $display("FAIL wide_count: got %0d expected 5", bus.mines_placed); end
        if (map_mismatches() != 0) begin errors++; $display("FAIL wide_map: got %0d differing cells expected 0", map_mismatches()); end
    endtask

    task automatic test_start_while_busy();
        start_pulse(10, 8, 2, 2);
        model_place(10, 8, 2, 2, snap);
        @(negedge clk);
        bus.mines_in   = 6'd30;
        bus.button_num = 5'd16;
        bus.safe_x     = 4'd0;
        bus.safe_y     = 4'd0;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_start_busy: got %b expected 1", bus.busy); end
        wait_done(1);
        read_map();
        checks += 4;
        if (done_edge != exp_done_edge) begin errors++; $display("FAIL busy_start_done_edge: got %0d expected %0d", done_edge, exp_done_edge); end
        if (done_pulses != 1) begin errors++; $display("FAIL busy_start_pulses: got %0d expected 1", done_pulses); end
        if (bus.mines_placed !== 6'd10) begin errors++; $display("FAIL busy_start_count: got %0d expected 10", bus.mines_placed); end
        if (map_mismatches() != 0) begin errors++; $display("FAIL busy_start_map: got %0d differing cells expected 0", map_mismatches()); end
        start_pulse(3, 8, 5, 5);
        model_place(3, 8, 5, 5, snap);
        wait_done(0);
        read_map();
        checks += 2;
        if (bus.mines_placed !== 6'd3) begin errors++; $display("FAIL restart_count: got %0d expected 3", bus.mines_placed); end
        if (map_mismatches() != 0) begin errors++; $display("FAIL restart_stale_map: got %0d differing cells expected 0", map_mismatches()); end
    endtask

    task automatic test_reset_mid_place();
        int dones;
        start_pulse(50, 16, 5, 5);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        checks += 4;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
        if (bus.mines_placed !== 6'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", bus.mines_placed); end
        if (bus.q_mine !== 1'b0) begin errors++; $display("FAIL midrst_qmine: got %b expected 0", bus.q_mine); end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL midrst_no_done: got %0d pulses expected 0", dones); end
        start_pulse(12, 8, 6, 1);
        model_place(12, 8, 6, 1, snap);
        wait_done(0);
        read_map();
        checks += 3;
        if (bus.mines_placed !== 6'd12) begin errors++; $display("FAIL postrst_count: got %0d expected 12", bus.mines_placed); end
        if (map_mismatches() != 0) begin errors++; $display("FAIL postrst_map: got %0d differing cells expected 0", map_mismatches()); end
        if (done_edge != exp_done_edge) begin errors++; $display("FAIL postrst_done_edge: got %0d expected %0d", done_edge, exp_done_edge); end
        bus.q_x = 4'd9;
        bus.q_y = 4'd2;
        @(posedge clk);
        #1;
        checks++;
        if (bus.q_mine !== 1'b0) begin errors++; $display("FAIL query_offboard: got %b expected 0", bus.q_mine); end
    endtask

    task automatic test_random();
        int mines, bn, sx, sy;
        for (int it = 0; it < 6; it++) begin
            mines = int'($urandom_range(0, 40));
            bn    = int'($urandom_range(6, 20));
            sx    = int'($urandom_range(0, 15));
            sy    = int'($urandom_range(0, 15));
            start_pulse(mines, bn, sx, sy);
            model_place(mines, bn, sx, sy, snap);
            wait_done(0);
            read_map();
            checks += 3;
            if (done_edge != exp_done_edge) begin errors++; $display("FAIL rand%0d_done_edge: got %0d expected %0d", it, done_edge, exp_done_edge); end
            if (int'(bus.mines_placed) != exp_target) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", it, bus.mines_placed, exp_target); end
            if (map_mismatches() != 0) begin errors++; $display("FAIL rand%0d_map: got %0d differing cells expected 0", it, map_mismatches()); end
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.mines_in   = 6'd0;
        bus.button_num = 5'd0;
        bus.safe_x     = 4'd0;
        bus.safe_y     = 4'd0;
        bus.q_x        = 4'd0;
        bus.q_y        = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_level1();
        test_level3();
        test_zero_mines();
        test_saturation();
        test_start_while_busy();
        test_reset_mid_place();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
